// File: rtl/burst_slave_port.sv
// burst_slave_port
// Serial-to-parallel slave port. It deserialises an address (LSB first), an
// optional burst length field and write data from the serial interconnect.
// It then runs ready/valid handshakes with a parallel target, and serialises
// read data back to the interconnect with ready/valid flow control.
//
// Ports:
//   in_clk, reset                 clock (rising edge) and async active-high reset
//   ss, ser_in_valid, ser_in      serial request stream; a bit is consumed on ss && ser_in_valid
//   in_write, burst_en            direction / burst flag, sampled with the first address bit
//   ser_out_ready/valid, ser_out  serial read-data stream, LSB first
//   busy                          high whenever the port is not idle
//   out_split_en                  split indication to the interconnect
//   par_out_valid, out_write,
//   out_addr, par_wdata           target request
//   par_in_ready, par_in_valid,
//   par_rdata, in_split_en        target response
//
// Optional feature macro: BURST_SLAVE_PORT_SPLIT_EN
//   When defined, a target split request in RS parks the port in SPLIT.
//   There it ignores ss until read data arrives. When undefined,
//   out_split_en is tied low and in_split_en is ignored.
module burst_slave_port #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              in_clk,
    input  logic              reset,
    input  logic              ss,
    input  logic              ser_in_valid,
    input  logic              ser_in,
    input  logic              in_write,
    input  logic              burst_en,
    input  logic              ser_out_ready,
    output logic              ser_out_valid,
    output logic              ser_out,
    output logic              busy,
    output logic              out_split_en,
    output logic              par_out_valid,
    output logic              out_write,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] par_wdata,
    input  logic              par_in_ready,
    input  logic              par_in_valid,
    input  logic [DATA_W-1:0] par_rdata,
    input  logic              in_split_en
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > LEN_W) ? ADDR_W : LEN_W)
                                             : ((DATA_W > LEN_W) ? DATA_W : LEN_W);
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_ADDR = 3'd1,
        ST_RX_LEN  = 3'd2,
        ST_RX_DATA = 3'd3,
        ST_WS      = 3'd4,
        ST_RS      = 3'd5,
        ST_TX      = 3'd6
`ifdef BURST_SLAVE_PORT_SPLIT_EN
        , ST_SPLIT = 3'd7
`endif
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               write_r;
    logic               burst_r;
    logic               abort_r;      // ss dropped during a target handshake
    logic [LEN_W-1:0]   beats_left_r;
    logic [LEN_W-1:0]   len_sr_r;
    logic [DATA_W-1:0]  tx_sr_r;
    logic [ADDR_W-1:0]  out_addr_r;
    logic [DATA_W-1:0]  par_wdata_r;
    logic               par_out_valid_r;
    logic               out_write_r;
    logic               busy_r;
    logic               ser_out_valid_r;
    logic               split_r;
    logic               tx_guard_r;   // suppresses TX abort until the first bit after a split
    logic               req_next_s;
    logic               split_next_s;

    logic bit_ok_s;
    logic last_beat_s;
    logic abort_now_s;
    logic tx_abort_s;
    logic tx_done_s;

    assign bit_ok_s    = ss && ser_in_valid;
    assign last_beat_s = (beats_left_r == LEN_ZERO);
    assign abort_now_s = abort_r || !ss;
    assign tx_abort_s  = !ss && !tx_guard_r;
    assign tx_done_s   = ser_out_ready && (cnt_r == DATA_LAST);

`ifndef BURST_SLAVE_PORT_SPLIT_EN
    logic unused_split_s;
    assign unused_split_s = in_split_en;
`endif

    assign ser_out_valid = ser_out_valid_r;
    assign ser_out       = tx_sr_r[0];
    assign busy          = busy_r;
    assign out_split_en  = split_r;
    assign par_out_valid = par_out_valid_r;
    assign out_write     = out_write_r;
    assign out_addr      = out_addr_r;
    assign par_wdata     = par_wdata_r;

    // Next-state decode plus the next values of the registered request/split outputs.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bit_ok_s) state_next_s = ST_RX_ADDR;
                else          state_next_s = ST_IDLE;
            end
            ST_RX_ADDR: begin
                if (!ss) begin
                    state_next_s = ST_IDLE;
                end else if (bit_ok_s && (cnt_r == ADDR_LAST)) begin
                    if (burst_r)      state_next_s = ST_RX_LEN;
                    else if (write_r) state_next_s = ST_RX_DATA;
                    else              state_next_s = ST_RS;
                end else begin
                    state_next_s = ST_RX_ADDR;
                end
            end
            ST_RX_LEN: begin
                if (!ss) begin
                    state_next_s = ST_IDLE;
                end else if (bit_ok_s && (cnt_r == LEN_LAST)) begin
                    if (write_r) state_next_s = ST_RX_DATA;
                    else         state_next_s = ST_RS;
                end else begin
                    state_next_s = ST_RX_LEN;
                end
            end
            ST_RX_DATA: begin
                if (!ss)                                       state_next_s = ST_IDLE;
                else if (bit_ok_s && (cnt_r == DATA_LAST))     state_next_s = ST_WS;
                else                                           state_next_s = ST_RX_DATA;
            end
            ST_WS: begin
                // The write always completes; a deselect only cancels later beats.
                if (par_in_ready) begin
                    if (last_beat_s || abort_now_s) state_next_s = ST_IDLE;
                    else                            state_next_s = ST_RX_DATA;
                end else begin
                    state_next_s = ST_WS;
                end
            end
            ST_RS: begin
                if (par_in_valid) begin
                    if (abort_now_s) state_next_s = ST_IDLE;
                    else             state_next_s = ST_TX;
                end
`ifdef BURST_SLAVE_PORT_SPLIT_EN
                else if (in_split_en) begin
                    state_next_s = ST_SPLIT;
                end
`endif
                else begin
                    state_next_s = ST_RS;
                end
            end
`ifdef BURST_SLAVE_PORT_SPLIT_EN
            ST_SPLIT: begin
                if (par_in_valid) state_next_s = ST_TX;
                else              state_next_s = ST_SPLIT;
            end
`endif
            ST_TX: begin
                if (tx_abort_s) begin
                    state_next_s = ST_IDLE;
                end else if (tx_done_s) begin
                    if (last_beat_s) state_next_s = ST_IDLE;
                    else             state_next_s = ST_RS;
                end else begin
                    state_next_s = ST_TX;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase

        req_next_s   = (state_next_s == ST_WS) || (state_next_s == ST_RS);
        split_next_s = 1'b0;
`ifdef BURST_SLAVE_PORT_SPLIT_EN
        req_next_s   = req_next_s || (state_next_s == ST_SPLIT);
        split_next_s = (state_next_s == ST_SPLIT);
`endif
    end

    // State register, datapath shift registers, counters and registered outputs.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO;
            write_r         <= 1'b0;
            burst_r         <= 1'b0;
            abort_r         <= 1'b0;
            beats_left_r    <= LEN_ZERO;
            len_sr_r        <= LEN_ZERO;
            tx_sr_r         <= {DATA_W{1'b0}};
            out_addr_r      <= {ADDR_W{1'b0}};
            par_wdata_r     <= {DATA_W{1'b0}};
            par_out_valid_r <= 1'b0;
            out_write_r     <= 1'b0;
            busy_r          <= 1'b0;
            ser_out_valid_r <= 1'b0;
            split_r         <= 1'b0;
            tx_guard_r      <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            par_out_valid_r <= req_next_s;
            out_write_r     <= (state_next_s == ST_WS);
            busy_r          <= (state_next_s != ST_IDLE);
            ser_out_valid_r <= (state_next_s == ST_TX);
            split_r         <= split_next_s;
            case (state_r)
                ST_IDLE: begin
                    abort_r <= 1'b0;
                    if (bit_ok_s) begin
                        write_r      <= in_write;
                        burst_r      <= burst_en;
                        beats_left_r <= LEN_ZERO;
                        out_addr_r   <= {ser_in, out_addr_r[ADDR_W-1:1]};
                        cnt_r        <= CNT_ONE;
                    end else begin
                        cnt_r <= CNT_ZERO;
                    end
                end
                ST_RX_ADDR: begin
                    if (bit_ok_s) begin
                        out_addr_r <= {ser_in, out_addr_r[ADDR_W-1:1]};
                        cnt_r      <= (cnt_r == ADDR_LAST) ? CNT_ZERO : cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RX_LEN: begin
                    if (bit_ok_s) begin
                        len_sr_r <= {ser_in, len_sr_r[LEN_W-1:1]};
                        if (cnt_r == LEN_LAST) begin
                            beats_left_r <= {ser_in, len_sr_r[LEN_W-1:1]};
                            cnt_r        <= CNT_ZERO;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RX_DATA: begin
                    if (bit_ok_s) begin
                        par_wdata_r <= {ser_in, par_wdata_r[DATA_W-1:1]};
                        cnt_r       <= (cnt_r == DATA_LAST) ? CNT_ZERO : cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_WS: begin
                    abort_r <= abort_now_s;
                    cnt_r   <= CNT_ZERO;
                    if (state_next_s == ST_RX_DATA) begin
                        out_addr_r   <= out_addr_r + ADDR_ONE;
                        beats_left_r <= beats_left_r - LEN_ONE;
                    end
                end
                ST_RS: begin
                    abort_r <= abort_now_s;
                    cnt_r   <= CNT_ZERO;
                    if (par_in_valid) tx_sr_r <= par_rdata;
                end
`ifdef BURST_SLAVE_PORT_SPLIT_EN
                ST_SPLIT: begin
                    cnt_r <= CNT_ZERO;
                    if (par_in_valid) begin
                        tx_sr_r    <= par_rdata;
                        tx_guard_r <= 1'b1;
                    end
                end
`endif
                ST_TX: begin
                    if (ser_out_ready) begin
                        tx_sr_r    <= {1'b0, tx_sr_r[DATA_W-1:1]};
                        tx_guard_r <= 1'b0;
                        cnt_r      <= tx_done_s ? CNT_ZERO : cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    if (state_next_s == ST_RS) begin
                        out_addr_r   <= out_addr_r + ADDR_ONE;
                        beats_left_r <= beats_left_r - LEN_ONE;
                    end
                end
                default: cnt_r <= CNT_ZERO;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_slave_port.sv
module tb_burst_slave_port;

    logic       in_clk = 1'b0;
    logic       reset = 1'b1;
    logic       ss = 1'b0;
    logic       ser_in_valid = 1'b0;
    logic       ser_in = 1'b0;
    logic       in_write = 1'b0;
    logic       burst_en = 1'b0;
    logic       ser_out_ready = 1'b0;
    logic       ser_out_valid;
    logic       ser_out;
    logic       busy;
    logic       out_split_en;
    logic       par_out_valid;
    logic       out_write;
    logic [11:0] out_addr;
    logic [7:0] par_wdata;
    logic       par_in_ready = 1'b0;
    logic       par_in_valid = 1'b0;
    logic [7:0] par_rdata = 8'h00;
    logic       in_split_en = 1'b0;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } xfer_t;

    xfer_t      exp_wr_q[$];
    xfer_t      exp_rd_q[$];
    logic [7:0] pend_rd_q[$];

    int checks = 0;
    int failures = 0;
    int pov_cycles = 0;
    int rx_bits = 0;
    logic [7:0] rx_byte = 8'h00;

    burst_slave_port dut (
        .in_clk        (in_clk),
        .reset         (reset),
        .ss            (ss),
        .ser_in_valid  (ser_in_valid),
        .ser_in        (ser_in),
        .in_write      (in_write),
        .burst_en      (burst_en),
        .ser_out_ready (ser_out_ready),
        .ser_out_valid (ser_out_valid),
        .ser_out       (ser_out),
        .busy          (busy),
        .out_split_en  (out_split_en),
        .par_out_valid (par_out_valid),
        .out_write     (out_write),
        .out_addr      (out_addr),
        .par_wdata     (par_wdata),
        .par_in_ready  (par_in_ready),
        .par_in_valid  (par_in_valid),
        .par_rdata     (par_rdata),
        .in_split_en   (in_split_en)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected transfers whenever the DUT completes a handshake.
    always @(negedge in_clk) begin
        if (!reset) begin
            if (par_out_valid) pov_cycles++;
            if (par_out_valid && out_write && par_in_ready) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    xfer_t e;
                    e = exp_wr_q.pop_front();
                    check("wr_addr", {20'd0, out_addr}, {20'd0, e.addr});
                    check("wr_data", {24'd0, par_wdata}, {24'd0, e.data});
                end
            end
            if (par_out_valid && !out_write && par_in_valid) begin
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                end else begin
                    xfer_t e;
                    e = exp_rd_q.pop_front();
                    check("rd_addr", {20'd0, out_addr}, {20'd0, e.addr});
                    pend_rd_q.push_back(e.data);
                    rx_bits = 0;
                end
            end
            if (ser_out_valid && ser_out_ready) begin
                rx_byte[rx_bits] = ser_out;
                rx_bits++;
                if (rx_bits == 8) begin
                    rx_bits = 0;
                    if (pend_rd_q.size() == 0) check("unexpected_serial", 32'd1, 32'd0);
                    else check("rd_serial_data", {24'd0, rx_byte}, {24'd0, pend_rd_q.pop_front()});
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge in_clk);
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ss = 1'b1;
        ser_in_valid = 1'b1;
        ser_in = b;
        tick();
        ser_in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [11:0] a, input logic wr, input logic bu);
        in_write = wr;
        burst_en = bu;
        for (int i = 0; i < 12; i++) send_bit(a[i]);
        in_write = 1'b0;
        burst_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic accept_write();
        int n;
        n = 0;
        while (!(par_out_valid && out_write) && n < 20) begin
            tick();
            n++;
        end
        check("ws_reached", {31'd0, par_out_valid && out_write}, 32'd1);
        par_in_ready = 1'b1;
        tick();
        par_in_ready = 1'b0;
    endtask

    task automatic give_rdata(input logic [7:0] d);
        par_rdata = d;
        par_in_valid = 1'b1;
        tick();
        par_in_valid = 1'b0;
        par_rdata = 8'h00;
        check("tx_entered", {31'd0, ser_out_valid}, 32'd1);
    endtask

    task automatic recv_serial(input logic alternate);
        int n;
        int guard;
        logic held;
        logic hold_pending;
        n = 0;
        guard = 0;
        held = 1'b0;
        hold_pending = 1'b0;
        while (n < 8 && guard < 64) begin
            ser_out_ready = alternate ? (guard % 2 == 0) : 1'b1;
            if (hold_pending) check("ser_out_hold", {31'd0, ser_out}, {31'd0, held});
            hold_pending = 1'b0;
            if (ser_out_valid && ser_out_ready) begin
                n++;
            end else if (ser_out_valid) begin
                held = ser_out;
                hold_pending = 1'b1;
            end
            tick();
            guard++;
        end
        ser_out_ready = 1'b0;
        check("serial_bits_done", n, 32'd8);
    endtask

    initial begin
        int pov_save;
        logic [11:0] a4;
        logic [3:0] len;

        repeat (2) @(posedge in_clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pov", {31'd0, par_out_valid}, 32'd0);
        check("rst_addr", {20'd0, out_addr}, 32'd0);
        check("rst_wdata", {24'd0, par_wdata}, 32'd0);
        check("rst_sov", {31'd0, ser_out_valid}, 32'd0);
        check("rst_split", {31'd0, out_split_en}, 32'd0);
        reset = 1'b0;
        tick();

        // single write, WS reached on the cycle after the 20th bit
        exp_wr_q.push_back('{12'hA5C, 8'h3E});
        send_header(12'hA5C, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(i[0] ? 1'b1 : (i == 2 || i == 4));
        check("t1_no_req_before_20", {31'd0, par_out_valid}, 32'd0);
        send_bit(1'b0);
        check("t1_req_after_20", {31'd0, par_out_valid}, 32'd1);
        check("t1_out_write", {31'd0, out_write}, 32'd1);
        tick();
        tick();
        check("t1_addr_stable", {20'd0, out_addr}, 32'h0A5C);
        check("t1_wdata_stable", {24'd0, par_wdata}, 32'h3E);
        par_in_ready = 1'b1;
        tick();
        par_in_ready = 1'b0;
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_req_drop", {31'd0, par_out_valid}, 32'd0);
        ss = 1'b0;
        tick();

        // read with 3-cycle target latency, ready alternating
        exp_rd_q.push_back('{12'h010, 8'hC3});
        send_header(12'h010, 1'b0, 1'b0);
        check("t2_rs_req", {31'd0, par_out_valid}, 32'd1);
        check("t2_rs_dir", {31'd0, out_write}, 32'd0);
        repeat (3) tick();
        check("t2_rs_wait", {31'd0, par_out_valid}, 32'd1);
        give_rdata(8'hC3);
        check("t2_req_drop", {31'd0, par_out_valid}, 32'd0);
        recv_serial(1'b1);
        check("t2_idle", {31'd0, busy}, 32'd0);
        ss = 1'b0;
        tick();

        // 3-beat write burst wrapping the address
        exp_wr_q.push_back('{12'hFFE, 8'h11});
        exp_wr_q.push_back('{12'hFFF, 8'h22});
        exp_wr_q.push_back('{12'h000, 8'h33});
        send_header(12'hFFE, 1'b1, 1'b1);
        len = 4'd2;
        for (int i = 0; i < 4; i++) send_bit(len[i]);
        send_byte(8'h11);
        accept_write();
        check("t3_beat2_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h22);
        accept_write();
        send_byte(8'h33);
        check("t3_wrap_addr", {20'd0, out_addr}, 32'h000);
        accept_write();
        check("t3_idle", {31'd0, busy}, 32'd0);
        ss = 1'b0;
        tick();

        // stall mid-address, then deselect mid-data: nothing reaches the target
        pov_save = pov_cycles;
        a4 = 12'h123;
        in_write = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(a4[i]);
        in_write = 1'b0;
        repeat (5) tick();
        check("t4_stall_busy", {31'd0, busy}, 32'd1);
        for (int i = 5; i < 12; i++) send_bit(a4[i]);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("t4_rxdata_busy", {31'd0, busy}, 32'd1);
        ss = 1'b0;
        tick();
        check("t4_abort_idle", {31'd0, busy}, 32'd0);
        check("t4_abort_no_req", {31'd0, par_out_valid}, 32'd0);
        check("t4_no_req_seen", pov_cycles, pov_save);
        tick();

        // async reset while a read request is pending
        send_header(12'h2AB, 1'b0, 1'b0);
        check("t5_rs_req", {31'd0, par_out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_pov", {31'd0, par_out_valid}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_addr", {20'd0, out_addr}, 32'd0);
        check("t5_rst_sov", {31'd0, ser_out_valid}, 32'd0);
        #2 reset = 1'b0;
        ss = 1'b0;
        tick();
        exp_rd_q.push_back('{12'h001, 8'h96});
        send_header(12'h001, 1'b0, 1'b0);
        check("t5_read_req", {31'd0, par_out_valid}, 32'd1);
        tick();
        give_rdata(8'h96);
        recv_serial(1'b0);
        check("t5_idle", {31'd0, busy}, 32'd0);
        ss = 1'b0;
        tick();

        // split request from the target during a read
        exp_rd_q.push_back('{12'h0F0, 8'h5A});
        send_header(12'h0F0, 1'b0, 1'b0);
        in_split_en = 1'b1;
        tick();
`ifdef BURST_SLAVE_PORT_SPLIT_EN
        check("t6_split_set", {31'd0, out_split_en}, 32'd1);
        check("t6_split_req", {31'd0, par_out_valid}, 32'd1);
        ss = 1'b0;
        repeat (2) tick();
        check("t6_split_ss_ignored", {31'd0, busy}, 32'd1);
        check("t6_split_held", {31'd0, out_split_en}, 32'd1);
        ss = 1'b1;
`else
        check("t6_split_tied", {31'd0, out_split_en}, 32'd0);
        check("t6_still_rs", {31'd0, par_out_valid}, 32'd1);
        tick();
        check("t6_split_tied2", {31'd0, out_split_en}, 32'd0);
`endif
        in_split_en = 1'b0;
        give_rdata(8'h5A);
        check("t6_split_clear", {31'd0, out_split_en}, 32'd0);
        recv_serial(1'b0);
        check("t6_idle", {31'd0, busy}, 32'd0);
        ss = 1'b0;
        repeat (2) tick();

        check("end_wr_q_empty", exp_wr_q.size(), 32'd0);
        check("end_rd_q_empty", exp_rd_q.size(), 32'd0);
        check("end_pend_empty", pend_rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
